// File: rtl/baud_rate_ctrl.sv
// baud_rate_ctrl: arbitrated reprogramming of the UART baud rate generator.
// Two requesters are granted round-robin. Before the generator is updated, the
// UART is held off until any in-flight frame drains. The requester is
// acknowledged only after the new rate has produced SETTLE_EDGES rising edges.
// Optional feature macro: BAUD_CTRL_TIMEOUT_EN bounds the drain wait to
// TIMEOUT_CYCLES cycles and rejects the request (o_err) if that bound expires.
module baud_rate_ctrl #(
    parameter int          SETTLE_EDGES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic [3:0] i_sel0,
    input  logic [3:0] i_sel1,
    output logic [1:0] o_ack,
    output logic       o_err,
    input  logic       i_uart_busy,
    output logic       o_hold,
    output logic [3:0] o_baud_select,
    output logic       o_update_baud,
    input  logic       i_baud_rising,
    output logic [3:0] o_current_sel
);

`ifdef BAUD_CTRL_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam logic [31:0] TMO_LAST   = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]  SETTLE_CNT = 5'(SETTLE_EDGES);
    localparam logic [3:0]  MAX_SEL    = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_UPDATE,
        ST_SETTLE,
        ST_ACK
    } state_e;

    state_e      state_q, state_d;
    logic        rr_q, rr_d;              // requester holding priority
    logic        g_q, g_d;                // granted requester
    logic [3:0]  sel_q, sel_d;            // select code latched at grant
    logic        err_q, err_d;            // transaction will be rejected
    logic [3:0]  cnt_q, cnt_d;            // counted settle edges
    logic        first_q, first_d;        // first SETTLE cycle, edges ignored
    logic [31:0] tmo_q, tmo_d;            // drain-wait cycle counter

    logic [1:0]  ack_q, ack_d;
    logic        err_out_q, err_out_d;
    logic        hold_q, hold_d;
    logic [3:0]  baud_select_q, baud_select_d;
    logic        update_q, update_d;
    logic [3:0]  current_sel_q, current_sel_d;

    logic        grant_idx;
    logic [3:0]  grant_sel;

    // Next-state logic; registered outputs are derived from the next state so
    // they line up exactly with the state they belong to.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d       = state_q;
        rr_d          = rr_q;
        g_d           = g_q;
        sel_d         = sel_q;
        err_d         = err_q;
        cnt_d         = cnt_q;
        first_d       = 1'b0;
        tmo_d         = tmo_q;
        baud_select_d = baud_select_q;
        current_sel_d = current_sel_q;

        grant_idx = i_req[rr_q] ? rr_q : ~rr_q;
        grant_sel = grant_idx ? i_sel1 : i_sel0;

        case (state_q)
            ST_IDLE: begin
                if (|i_req) begin
                    g_d   = grant_idx;
                    sel_d = grant_sel;
                    rr_d  = ~grant_idx;
                    tmo_d = '0;
                    if (grant_sel > MAX_SEL) begin
                        err_d   = 1'b1;
                        state_d = ST_ACK;
                    end else if (grant_sel == current_sel_q) begin
                        err_d   = 1'b0;
                        state_d = ST_ACK;
                    end else begin
                        err_d         = 1'b0;
                        baud_select_d = grant_sel;
                        state_d       = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!i_uart_busy) begin
                    state_d = ST_UPDATE;
                end else if (TIMEOUT_EN && (tmo_q == TMO_LAST)) begin
                    err_d   = 1'b1;
                    state_d = ST_ACK;
                end else if (TIMEOUT_EN) begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            ST_UPDATE: begin
                current_sel_d = sel_q;
                cnt_d         = '0;
                first_d       = 1'b1;
                state_d       = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!first_q && i_baud_rising) begin
                    if (({1'b0, cnt_q} + 5'd1) == SETTLE_CNT) begin
                        state_d = ST_ACK;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        hold_d    = (state_d == ST_DRAIN) || (state_d == ST_UPDATE) ||
                    (state_d == ST_SETTLE);
        update_d  = (state_d == ST_UPDATE);
        err_out_d = (state_d == ST_ACK) && err_d;
        ack_d     = 2'b00;
        if (state_d == ST_ACK) begin
            ack_d[g_d] = 1'b1;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            rr_q          <= 1'b0;
            g_q           <= 1'b0;
            sel_q         <= '0;
            err_q         <= 1'b0;
            cnt_q         <= '0;
            first_q       <= 1'b0;
            tmo_q         <= '0;
            ack_q         <= '0;
            err_out_q     <= 1'b0;
            hold_q        <= 1'b0;
            baud_select_q <= '0;
            update_q      <= 1'b0;
            current_sel_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            rr_q          <= rr_d;
            g_q           <= g_d;
            sel_q         <= sel_d;
            err_q         <= err_d;
            cnt_q         <= cnt_d;
            first_q       <= first_d;
            tmo_q         <= tmo_d;
            ack_q         <= ack_d;
            err_out_q     <= err_out_d;
            hold_q        <= hold_d;
            baud_select_q <= baud_select_d;
            update_q      <= update_d;
            current_sel_q <= current_sel_d;
        end
    end

    assign o_ack         = ack_q;
    assign o_err         = err_out_q;
    assign o_hold        = hold_q;
    assign o_baud_select = baud_select_q;
    assign o_update_baud = update_q;
    assign o_current_sel = current_sel_q;

endmodule

// File: tb/tb_baud_rate_ctrl.sv
// Testbench for baud_rate_ctrl: randomized transactions checked against a
// timeline model built from the request/drain/update/settle/ack rules.
module tb_baud_rate_ctrl;

    localparam int SETTLE = 2;
`ifdef BAUD_CTRL_TIMEOUT_EN
    localparam int TMO = 20;
`else
    localparam int TMO = 1_000_000;
`endif
    localparam int NPULSE = 320;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [1:0] i_req;
    logic [3:0] i_sel0;
    logic [3:0] i_sel1;
    logic [1:0] o_ack;
    logic       o_err;
    logic       i_uart_busy;
    logic       o_hold;
    logic [3:0] o_baud_select;
    logic       o_update_baud;
    logic       i_baud_rising;
    logic [3:0] o_current_sel;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [3:0] m_cur;
    logic [3:0] m_bsel;
    logic       m_rr;
    bit         pulse [NPULSE];

    baud_rate_ctrl #(
        .SETTLE_EDGES  (SETTLE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req        (i_req),
        .i_sel0       (i_sel0),
        .i_sel1       (i_sel1),
        .o_ack        (o_ack),
        .o_err        (o_err),
        .i_uart_busy  (i_uart_busy),
        .o_hold       (o_hold),
        .o_baud_select(o_baud_select),
        .o_update_baud(o_update_baud),
        .i_baud_rising(i_baud_rising),
        .o_current_sel(o_current_sel)
    );

    always #5 i_clk = ~i_clk;

    // One transaction, entered and left on a negedge. Negedge 0 drives the
    // request; outputs are checked on every later negedge until one idle
    // cycle after the ack. Returns the requester the model expects granted.
    task automatic txn(input string name, input logic [1:0] req,
                       input logic [3:0] s0, input logic [3:0] s1,
                       input int blen, input int pct, output logic granted);
        logic       g;
        logic [3:0] sel;
        bit         err;
        bit         upd;
        bit         tmo;
        int         u;
        int         ack_t;
        int         cnt;
        logic [3:0] old_cur;
        logic [3:0] old_bsel;
        logic [1:0] ack_1h;
        logic [1:0] req_now;
        logic [4:0] exp_ctl;
        logic [4:0] act_ctl;
        logic [7:0] exp_dat;
        logic [7:0] act_dat;

        g       = req[m_rr] ? m_rr : ~m_rr;
        sel     = g ? s1 : s0;
        m_rr    = ~g;
        granted = g;
        for (int j = 0; j < NPULSE; j++)
            pulse[j] = ($urandom_range(99) < pct) || (j >= 250);

        err      = (sel > 4'd9);
        upd      = !err && (sel != m_cur);
        tmo      = 1'b0;
        u        = -1;
        ack_t    = 1;
        old_cur  = m_cur;
        old_bsel = m_bsel;
        if (upd) begin
`ifdef BAUD_CTRL_TIMEOUT_EN
            if (blen >= TMO + 1) begin
                tmo   = 1'b1;
                err   = 1'b1;
                ack_t = TMO + 1;
            end
`endif
            if (!tmo) begin
                u     = ((blen < 1) ? 1 : blen) + 1;
                cnt   = 0;
                ack_t = -1;
                for (int j = u + 2; j < NPULSE - 2; j++) begin
                    if (pulse[j] && ack_t < 0) begin
                        cnt++;
                        if (cnt == SETTLE) ack_t = j + 1;
                    end
                end
            end
        end
        ack_1h  = g ? 2'b10 : 2'b01;
        req_now = req;

        for (int j = 0; j <= ack_t + 1; j++) begin
            if (j >= 1) begin
                exp_ctl = {upd && (j < ack_t), (j == u),
                           (j == ack_t) ? ack_1h : 2'b00, (j == ack_t) && err};
                act_ctl = {o_hold, o_update_baud, o_ack, o_err};
                n_tests++;
                if (act_ctl !== exp_ctl) begin
                    n_fail++;
                    $display("FAIL %s ctl @%0d: hold/upd/ack/err got %b want %b",
                             name, j, act_ctl, exp_ctl);
                end
                exp_dat = {upd ? sel : old_bsel,
                           (u >= 0 && j >= u + 1) ? sel : old_cur};
                act_dat = {o_baud_select, o_current_sel};
                n_tests++;
                if (act_dat !== exp_dat) begin
                    n_fail++;
                    $display("FAIL %s sel @%0d: baud_select/current_sel got %h want %h",
                             name, j, act_dat, exp_dat);
                end
            end
            if (j == ack_t + 1) break;
            if (j == ack_t) req_now[g] = 1'b0;
            i_req         = req_now;
            i_sel0        = s0;
            i_sel1        = s1;
            i_uart_busy   = (j < blen);
            i_baud_rising = pulse[j];
            @(negedge i_clk);
        end
        i_req         = req_now;
        i_uart_busy   = 1'b0;
        i_baud_rising = 1'b0;
        if (upd) m_bsel = sel;
        if (u >= 0) m_cur = sel;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_req = '0; i_sel0 = '0; i_sel1 = '0;
        i_uart_busy = 1'b0; i_baud_rising = 1'b0;
        repeat (3) @(negedge i_clk);
        n_tests++;
        if ({o_ack, o_err, o_hold, o_baud_select, o_update_baud, o_current_sel} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_in: outputs got %b want 0",
                     {o_ack, o_err, o_hold, o_baud_select, o_update_baud, o_current_sel});
        end
        i_rst_n = 1'b1;
        m_cur = '0; m_bsel = '0; m_rr = 1'b0;
        @(negedge i_clk);
        n_tests++;
        if ({o_ack, o_err, o_hold, o_baud_select, o_update_baud, o_current_sel} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_idle: outputs got %b want 0",
                     {o_ack, o_err, o_hold, o_baud_select, o_update_baud, o_current_sel});
        end
    endtask

    task automatic test_noop();
        logic g;
        txn("noop", 2'b01, 4'd0, 4'd0, 0, 50, g);
    endtask

    task automatic test_basic();
        logic g;
        txn("basic", 2'b01, 4'd4, 4'd0, 0, 50, g);
    endtask

    task automatic test_invalid();
        logic g;
        txn("invalid", 2'b10, 4'd4, 4'd12, 0, 50, g);
    endtask

    task automatic test_simultaneous();
        logic g;
        txn("simul_a", 2'b11, 4'd2, 4'd7, 1, 60, g);
        txn("simul_b", g ? 2'b01 : 2'b10, 4'd2, 4'd7, 1, 60, g);
        n_tests++;
        if (o_current_sel !== 4'd7) begin
            n_fail++;
            $display("FAIL simul_final: current_sel got %0d want 7", o_current_sel);
        end
    endtask

    task automatic test_drain();
        logic g;
        logic [3:0] s;
        s = (m_cur == 4'd5) ? 4'd6 : 4'd5;
        txn("drain", 2'b01, s, 4'd0, 50, 40, g);
    endtask

    task automatic test_random();
        logic       g;
        logic [1:0] pend;
        logic [1:0] req;
        logic [3:0] s0;
        logic [3:0] s1;
        pend = 2'b00; s0 = '0; s1 = '0;
        for (int t = 0; t < 30; t++) begin
            if (!pend[0]) s0 = ($urandom_range(4) == 0) ? m_cur : 4'($urandom_range(15));
            if (!pend[1]) s1 = ($urandom_range(4) == 0) ? m_cur : 4'($urandom_range(15));
            req = pend | 2'($urandom_range(1, 3));
            txn("random", req, s0, s1, $urandom_range(8), $urandom_range(20, 90), g);
            pend = req;
            pend[g] = 1'b0;
        end
        // serve any leftover requester so the bus ends idle
        if (pend != 2'b00) txn("random_tail", pend, s0, s1, 0, 50, g);
    endtask

    task automatic test_reset_mid();
        logic [3:0] s;
        s = (m_cur == 4'd3) ? 4'd8 : 4'd3;
        i_sel0 = s; i_req = 2'b01; i_uart_busy = 1'b0; i_baud_rising = 1'b0;
        repeat (4) @(negedge i_clk);
        n_tests++;
        if (o_hold !== 1'b1 || o_current_sel !== s) begin
            n_fail++;
            $display("FAIL reset_mid_pre: hold/current_sel got %b/%0d want 1/%0d",
                     o_hold, o_current_sel, s);
        end
        i_rst_n = 1'b0;
        i_req   = 2'b00;
        i_baud_rising = 1'b1;
        @(negedge i_clk);
        n_tests++;
        if ({o_ack, o_err, o_hold, o_baud_select, o_update_baud, o_current_sel} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_mid: outputs got %b want 0",
                     {o_ack, o_err, o_hold, o_baud_select, o_update_baud, o_current_sel});
        end
        i_rst_n = 1'b1;
        i_baud_rising = 1'b0;
        m_cur = '0; m_bsel = '0; m_rr = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge i_clk);
            n_tests++;
            if (o_ack !== 2'b00 || o_hold !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_after @%0d: ack/hold got %b/%b want 00/0",
                         j, o_ack, o_hold);
            end
        end
    endtask

    initial begin
        test_reset();
        test_noop();
        test_basic();
        test_invalid();
        test_simultaneous();
        test_drain();
        test_random();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/baud_rate_ctrl.md
# baud_rate_ctrl

Arbitrated configuration controller for the UART baud rate generator. Accepts rate-change requests from two requesters, such as the host CSR port and an auto-baud engine, and grants them round-robin. Before reprogramming the generator, it holds off the UART until any in-flight frame drains. It then issues the generator's select/update pair and acknowledges the requester only after the new rate has produced a configurable number of slow-clock rising edges.

## Interface
Parameters:
- SETTLE_EDGES, default 2: baud rising edges counted after update before ack (1..15).
- TIMEOUT_CYCLES, default 1_000_000: drain-wait limit in i_clk cycles; used only with BAUD_CTRL_TIMEOUT_EN.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  synchronous, active-low reset
- i_req  in  2  per-requester level request; held high until its o_ack bit pulses
- i_sel0  in  4  requested select code, requester 0
- i_sel1  in  4  requested select code, requester 1
- o_ack  out  2  one-cycle completion pulse to the granted requester
- o_err  out  1  one-cycle pulse coincident with o_ack when the request was rejected
- i_uart_busy  in  1  TX or RX frame in progress
- o_hold  out  1  UART must not start new frames while high
- o_baud_select  out  4  to generator select input; registered
- o_update_baud  out  1  to generator update input; one-cycle pulse
- i_baud_rising  in  1  generator rising-edge pulse
- o_current_sel  out  4  select code currently programmed

## Operation
States: IDLE, DRAIN, UPDATE, SETTLE, ACK. All outputs are registered.
- **IDLE**
  - If any i_req bit is high, grant it round-robin.
  - Priority goes to the requester not granted last; after reset, requester 0 has priority.
  - Latch the granted requester's select into sel_q and the grant index into g_q.
  - If sel_q > 9: go to ACK with err flag set.
  - If sel_q == o_current_sel: go to ACK without err, and no update is issued.
  - Otherwise: go to DRAIN.
- **DRAIN**
  - o_hold = 1.
  - When i_uart_busy is sampled low, go to UPDATE.
- **UPDATE**
  - o_update_baud = 1 for exactly this cycle; o_hold = 1.
  - o_baud_select = sel_q; it is driven from entry to DRAIN onward and held until the next update.
  - Next state: SETTLE.
  - o_current_sel <= sel_q, visible from the first SETTLE cycle.
- **SETTLE**
  - o_hold = 1.
  - Count i_baud_rising pulses with a 4-bit counter that is cleared on entry.
  - When the count reaches SETTLE_EDGES, go to ACK.
  - i_baud_rising pulses arriving in UPDATE or in the first SETTLE cycle are ignored.
- **ACK**
  - o_ack[g_q] = 1 and o_err = err flag for one cycle; o_hold = 0.
  - Next state: IDLE.
  - The requester drops i_req on the cycle after ack. A request still high in IDLE is treated as a new request.
- **Simultaneous requests:** only one is granted; the other waits and is granted next in IDLE.
- **Requests during non-IDLE states:** ignored until IDLE; i_sel is sampled only at grant.

Reset values:
- o_ack = 0, o_err = 0, o_hold = 0, o_update_baud = 0.
- o_baud_select = 0 and o_current_sel = 0, matching the generator's 9600 reset rate.
- State IDLE, round-robin pointer set to requester 0.

A reset mid-operation aborts the transaction: no ack is issued and o_hold drops on the next cycle.

## Timing
- A request sampled in IDLE at edge k puts the block in DRAIN at k+1, with o_hold high from k+1.
- From busy sampled low in DRAIN at edge m: UPDATE at m+1, SETTLE at m+2.
- ACK falls one cycle after the counted edge that reaches SETTLE_EDGES.
- Rejected or no-op request: ACK at k+1, for a total latency of 2 cycles.
- The generator needs 2 i_clk cycles after the update pulse; SETTLE covers this margin by construction.

## Configuration
- BAUD_CTRL_TIMEOUT_EN defined:
  - A 32-bit counter runs in DRAIN.
  - If i_uart_busy stays high for TIMEOUT_CYCLES cycles, go to ACK with o_err = 1.
  - No update is issued and o_current_sel is unchanged.
- Not defined: DRAIN waits indefinitely, and TIMEOUT_CYCLES is unused.

## Test plan
- **Basic change:** reset, then i_req=01 with i_sel0=4 and busy low.
  - One update pulse with o_baud_select=4.
  - o_current_sel=4.
  - o_ack=01 after the 2nd rising edge, with o_err=0.
- **Simultaneous requests:** i_req=11 with sel0=2, sel1=7.
  - Requester 0 is served first, then requester 1.
  - Final o_current_sel=7; the ack order is 01 then 10.
- **Invalid select:** i_sel1=12 -> o_ack=10 with o_err=1 two cycles after the request; no update pulse; o_current_sel unchanged.
- **No-op:** request sel=0 right after reset -> ack with no err and no update pulse.
- **Drain:** hold busy high for 50 cycles after the request.
  - o_hold is high throughout.
  - The update pulse occurs exactly 1 cycle after busy falls.
  - With BAUD_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=20, the request is instead acked with err after 20 cycles.
- **Mid-operation reset:** assert reset during SETTLE.
  - All outputs return to reset values on the next cycle.
  - No o_ack is issued.
